exception_ctrl: RTL and testbench

- Sequential exception unit directly downstream of the main decoder.
- Consumes the decoder's NotAnInstr, InconBranch and ERet flags, plus a synchronised external interrupt.
- Captures ELR/ESR, redirects fetch to the exception vector, flushes the pipeline and performs the return on ERET.
- Supplies system-register read data to the MRS datapath mux.

---
 rtl/exception_ctrl_if.sv | 33 +++
 rtl/exception_ctrl.sv | 153 +++++++++++++++
 tb/tb_exception_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/exception_ctrl_if.sv
// Decode-stage to exception-unit bundle: decoder flags and IRQ in,
// redirect/flush pulses and system-register read data out.
interface exception_ctrl_if #(
  parameter int DW = 64
) ();
  logic          InstrValid;
  logic [DW-1:0] PC_D;
  logic          NotAnInstr;
  logic          InconBranch;
  logic          ERet;
  logic          ExtIRQ;
  logic [1:0]    SysRegSel;
  logic          Exc;
  logic [DW-1:0] ExcPC;
  logic          ERetTaken;
  logic [DW-1:0] ELR;
  logic [3:0]    ESR;
  logic          InHandler;
  logic          IRQAck;
  logic [DW-1:0] SysRegData;

  // Decoder / pipeline side
  modport master (
    output InstrValid, PC_D, NotAnInstr, InconBranch, ERet, ExtIRQ, SysRegSel,
    input  Exc, ExcPC, ERetTaken, ELR, ESR, InHandler, IRQAck, SysRegData
  );

  // Exception unit side
  modport slave (
    input  InstrValid, PC_D, NotAnInstr, InconBranch, ERet, ExtIRQ, SysRegSel,
    output Exc, ExcPC, ERetTaken, ELR, ESR, InHandler, IRQAck, SysRegData
  );
endinterface

// File: rtl/exception_ctrl.sv
// Exception unit: captures ELR/ESR, redirects fetch to the vector, performs
// ERET, synchronises the external IRQ and serves MRS system-register reads.
module exception_ctrl #(
  parameter int            DW          = 64,
  parameter logic [DW-1:0] VECTOR_ADDR = 64'h0000_0000_0000_00D8,
  parameter int            SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset,
  exception_ctrl_if.slave bus
);

  localparam logic [3:0] ESR_UNDEF = 4'b0001;
  localparam logic [3:0] ESR_BRANCH = 4'b0010;
  localparam logic [3:0] ESR_IRQ = 4'b0100;
  localparam logic [3:0] ESR_ERET = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_TAKE    = 2'b01,
    ST_HANDLER = 2'b10,
    ST_RET     = 2'b11
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   irq_d_r;
  logic                   pending_r;
  logic [DW-1:0]          elr_r;
  logic [DW-1:0]          excpc_r;
  logic [3:0]             esr_r;
  logic                   exc_r;
  logic                   eret_taken_r;
  logic                   irq_ack_r;
  logic                   in_handler_r;

  logic                   irq_s;
  logic                   irq_rise_s;
  logic [3:0]             hit_code_s;
  logic                   accept_s;
  logic [DW-1:0]          sys_rd_s;

  assign irq_s      = sync_r[SYNC_STAGES-1];
  assign irq_rise_s = irq_s & ~irq_d_r;

  // Exception source selection in IDLE; decoder flags only count with a valid instruction
  always_comb begin
    hit_code_s = 4'b0000;
    if (bus.InstrValid && bus.NotAnInstr) begin
      hit_code_s = ESR_UNDEF;
    end else if (bus.InstrValid && bus.InconBranch) begin
      hit_code_s = ESR_BRANCH;
    end else if (bus.InstrValid && bus.ERet) begin
      hit_code_s = ESR_ERET;
    end else if (pending_r) begin
      hit_code_s = ESR_IRQ;
    end else begin
      hit_code_s = 4'b0000;
    end
    accept_s = (state_r == ST_IDLE) && (hit_code_s == ESR_IRQ);
  end

  // IRQ synchroniser, edge detector and pending latch (a new edge wins over acceptance)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r    <= {SYNC_STAGES{1'b0}};
      irq_d_r   <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], bus.ExtIRQ};
      irq_d_r   <= irq_s;
      pending_r <= irq_rise_s | (pending_r & ~accept_s);
    end
  end

  // Exception FSM with registered pulses and syndrome/link registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      elr_r        <= {DW{1'b0}};
      esr_r        <= 4'b0000;
      excpc_r      <= {DW{1'b0}};
      exc_r        <= 1'b0;
      eret_taken_r <= 1'b0;
      irq_ack_r    <= 1'b0;
      in_handler_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          exc_r        <= 1'b0;
          eret_taken_r <= 1'b0;
          irq_ack_r    <= 1'b0;
          if (hit_code_s != 4'b0000) begin
            state_r   <= ST_TAKE;
            exc_r     <= 1'b1;
            elr_r     <= bus.PC_D;
            esr_r     <= hit_code_s;
            excpc_r   <= VECTOR_ADDR;
            irq_ack_r <= accept_s;
          end
        end
        ST_TAKE: begin
          exc_r        <= 1'b0;
          irq_ack_r    <= 1'b0;
          in_handler_r <= 1'b1;
          state_r      <= ST_HANDLER;
        end
        ST_HANDLER: begin
          if (bus.InstrValid && bus.ERet) begin
            state_r      <= ST_RET;
            eret_taken_r <= 1'b1;
            excpc_r      <= elr_r;
          end
        end
        ST_RET: begin
          eret_taken_r <= 1'b0;
          in_handler_r <= 1'b0;
          esr_r        <= 4'b0000;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          exc_r        <= 1'b0;
          eret_taken_r <= 1'b0;
          irq_ack_r    <= 1'b0;
          in_handler_r <= 1'b0;
        end
      endcase
    end
  end

  // MRS read mux
  always_comb begin
    sys_rd_s = {DW{1'b0}};
    case (bus.SysRegSel)
      2'b00:   sys_rd_s = elr_r;
      2'b01:   sys_rd_s = {{(DW-4){1'b0}}, esr_r};
      2'b10:   sys_rd_s = {{(DW-2){1'b0}}, pending_r, in_handler_r};
      2'b11:   sys_rd_s = {DW{1'b0}};
      default: sys_rd_s = {DW{1'b0}};
    endcase
  end

  assign bus.Exc        = exc_r;
  assign bus.ExcPC      = excpc_r;
  assign bus.ERetTaken  = eret_taken_r;
  assign bus.ELR        = elr_r;
  assign bus.ESR        = esr_r;
  assign bus.InHandler  = in_handler_r;
  assign bus.IRQAck     = irq_ack_r;
  assign bus.SysRegData = sys_rd_s;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a flag-level model.
module tb_exception_ctrl;
  localparam int          DW   = 64;
  localparam int          SYNC = 2;
  localparam logic [63:0] VEC  = 64'h0000_0000_0000_00D8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  exception_ctrl_if #(.DW(DW)) bus ();

  exception_ctrl #(.DW(DW), .VECTOR_ADDR(VEC), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what the outputs must look like, tracked per clock edge
  bit          m_exc, m_eret, m_ack, m_inh, m_pend;
  logic [63:0] m_elr   = 64'd0;
  logic [63:0] m_excpc = 64'd0;
  logic [3:0]  m_esr   = 4'd0;
  bit          hist[SYNC+1];  // hist[k]: ExtIRQ as sampled k+1 edges ago

  task automatic model_reset();
    m_exc = 1'b0; m_eret = 1'b0; m_ack = 1'b0; m_inh = 1'b0; m_pend = 1'b0;
    m_elr = 64'd0; m_excpc = 64'd0; m_esr = 4'd0;
    for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
  endtask

  task automatic model_step();
    bit         rise, accept;
    logic [3:0] code;
    rise   = hist[SYNC-1] && !hist[SYNC];
    accept = 1'b0;
    if (m_exc) begin
      m_exc = 1'b0; m_ack = 1'b0; m_inh = 1'b1;
    end else if (m_eret) begin
      m_eret = 1'b0; m_inh = 1'b0; m_esr = 4'd0;
    end else if (m_inh) begin
      if (bus.InstrValid && bus.ERet) begin
        m_eret = 1'b1; m_excpc = m_elr;
      end
    end else begin
      if (bus.InstrValid && bus.NotAnInstr)       code = 4'd1;
      else if (bus.InstrValid && bus.InconBranch) code = 4'd2;
      else if (bus.InstrValid && bus.ERet)        code = 4'd8;
      else if (m_pend)                            code = 4'd4;
      else                                        code = 4'd0;
      if (code != 4'd0) begin
        m_exc = 1'b1; m_elr = bus.PC_D; m_esr = code; m_excpc = VEC;
        accept = (code == 4'd4);
        m_ack  = accept;
      end
    end
    m_pend = rise || (m_pend && !accept);
    for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bus.ExtIRQ;
  endtask

  function automatic logic [63:0] model_sysrd(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_elr;
      2'd1:    return {60'd0, m_esr};
      2'd2:    return {62'd0, m_pend, m_inh};
      default: return 64'd0;
    endcase
  endfunction

  // Per-cycle compare against the model
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (reset !== 1'b1) model_reset();
      else model_step();
      #1;
      chk("Exc", bus.Exc, {63'd0, m_exc});
      chk("ERetTaken", bus.ERetTaken, {63'd0, m_eret});
      chk("IRQAck", bus.IRQAck, {63'd0, m_ack});
      chk("InHandler", bus.InHandler, {63'd0, m_inh});
      chk("ELR", bus.ELR, m_elr);
      chk("ESR", bus.ESR, {60'd0, m_esr});
      chk("ExcPC", bus.ExcPC, m_excpc);
      chk("SysRegData", bus.SysRegData, model_sysrd(bus.SysRegSel));
    end
  end

  task automatic quiet();
    bus.InstrValid  = 1'b0;
    bus.NotAnInstr  = 1'b0;
    bus.InconBranch = 1'b0;
    bus.ERet        = 1'b0;
  endtask

  task automatic wait_exc(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.Exc === 1'b1) found = 1'b1;
    end
    if (!found) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_return();
    @(negedge clk);
    bus.InstrValid = 1'b1; bus.ERet = 1'b1;
    @(negedge clk);
    quiet();
    @(negedge clk);
  endtask

  initial begin
    quiet();
    bus.PC_D = 64'd0; bus.ExtIRQ = 1'b0; bus.SysRegSel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_exc", bus.Exc, 64'd0);
    chk("rst_elr", bus.ELR, 64'd0);
    chk("rst_inh", bus.InHandler, 64'd0);
    reset = 1'b1;

    // Invalid opcode
    @(negedge clk);
    bus.PC_D = 64'h10; bus.InstrValid = 1'b1; bus.NotAnInstr = 1'b1;
    @(negedge clk);
    chk("undef_exc", bus.Exc, 64'd1);
    chk("undef_excpc", bus.ExcPC, 64'hD8);
    chk("undef_elr", bus.ELR, 64'h10);
    chk("undef_esr", bus.ESR, 64'h1);
    quiet();
    @(negedge clk);
    chk("handler_inh", bus.InHandler, 64'd1);
    chk("handler_exc", bus.Exc, 64'd0);
    bus.InstrValid = 1'b1; bus.ERet = 1'b1; bus.ExtIRQ = 1'b1;
    @(negedge clk);
    chk("ret_pulse", bus.ERetTaken, 64'd1);
    chk("ret_excpc", bus.ExcPC, 64'h10);
    quiet(); bus.PC_D = 64'h20;
    @(negedge clk);
    chk("ret_inh", bus.InHandler, 64'd0);
    chk("ret_esr", bus.ESR, 64'd0);
    chk("ret_noexc", bus.Exc, 64'd0);

    // IRQ raised inside the handler is taken after the return
    wait_exc("irq1");
    chk("irq1_ack", bus.IRQAck, 64'd1);
    chk("irq1_esr", bus.ESR, 64'h4);
    chk("irq1_elr", bus.ELR, 64'h20);
    @(negedge clk);
    do_return();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("irq_held_noexc", bus.Exc, 64'd0);
    end

    // Simultaneous flags with a just-pending IRQ: invalid opcode wins
    bus.ExtIRQ = 1'b0;
    repeat (4) @(negedge clk);
    bus.ExtIRQ = 1'b1;
    repeat (3) @(negedge clk);
    bus.SysRegSel = 2'd2;
    #1;
    chk("estatus_pend", bus.SysRegData, 64'h2);
    bus.PC_D = 64'h30; bus.InstrValid = 1'b1; bus.NotAnInstr = 1'b1; bus.InconBranch = 1'b1;
    @(negedge clk);
    chk("prio_exc", bus.Exc, 64'd1);
    chk("prio_esr", bus.ESR, 64'h1);
    chk("prio_elr", bus.ELR, 64'h30);
    chk("prio_noack", bus.IRQAck, 64'd0);
    quiet(); bus.SysRegSel = 2'd0; bus.PC_D = 64'h50;
    do_return();
    wait_exc("irq2");
    chk("irq2_ack", bus.IRQAck, 64'd1);
    chk("irq2_esr", bus.ESR, 64'h4);
    chk("irq2_elr", bus.ELR, 64'h50);
    @(negedge clk);
    do_return();

    // ERET outside the handler
    bus.PC_D = 64'h40; bus.InstrValid = 1'b1; bus.ERet = 1'b1;
    @(negedge clk);
    chk("eret_idle_exc", bus.Exc, 64'd1);
    chk("eret_idle_esr", bus.ESR, 64'h8);
    chk("eret_idle_elr", bus.ELR, 64'h40);
    quiet();

    // Asynchronous reset inside the handler
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_inh", bus.InHandler, 64'd0);
    chk("arst_exc", bus.Exc, 64'd0);
    chk("arst_excpc", bus.ExcPC, 64'd0);
    chk("arst_sysrd", bus.SysRegData, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.InstrValid  = ($urandom_range(0, 3) != 0);
      bus.PC_D        = {$urandom, $urandom};
      bus.NotAnInstr  = ($urandom_range(0, 15) == 0);
      bus.InconBranch = ($urandom_range(0, 15) == 0);
      bus.ERet        = ($urandom_range(0, 5) == 0);
      bus.SysRegSel   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bus.ExtIRQ = ~bus.ExtIRQ;
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
